clock12_timekeeper: RTL and testbench

//  12-hour timekeeping core with a button-driven set-mode FSM.

---
 rtl/clock12_timekeeper.sv | 153 +++++++++++++++
 tb/tb_clock12_timekeeper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock12_timekeeper.sv
// 12-hour timekeeping core with a button-driven set mode.
// Running time keeps advancing while staged hour/minute/AM-PM are edited; staged values commit on exit.
module clock12_timekeeper #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       is_on_i,
    input  logic       btn_set_i,
    input  logic       btn_up_i,
    output logic [3:0] hour_o,
    output logic [5:0] minute_o,
    output logic [5:0] second_o,
    output logic       is_pm_o,
    output logic [1:0] current_set_state_o,
    output logic [3:0] set_hour_o,
    output logic [5:0] set_min_o,
    output logic       set_isPM_o,
    output logic       sec_tick_o
);

    // state      | meaning
    // S_IDLE     | running, no edit in progress
    // S_SET_HOUR | btn_up steps staged hour 1..12
    // S_SET_MIN  | btn_up steps staged minute 0..59
    // S_SET_AMPM | btn_up toggles staged AM/PM; btn_set commits
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SET_HOUR = 2'd1,
        S_SET_MIN  = 2'd2,
        S_SET_AMPM = 2'd3
    } state_t;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [3:0]    hour_q, hour_d;
    logic [5:0]    minute_q, minute_d;
    logic [5:0]    second_q, second_d;
    logic          is_pm_q, is_pm_d;
    logic [3:0]    set_hour_q, set_hour_d;
    logic [5:0]    set_min_q, set_min_d;
    logic          set_is_pm_q, set_is_pm_d;
    logic          sec_tick_q, sec_tick_d;
    logic          presc_tc;

    assign presc_tc = (prescaler_q == PRESC_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            prescaler_q <= '0;
            hour_q      <= 4'd12;
            minute_q    <= 6'd0;
            second_q    <= 6'd0;
            is_pm_q     <= 1'b0;
            set_hour_q  <= 4'd12;
            set_min_q   <= 6'd0;
            set_is_pm_q <= 1'b0;
            sec_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            second_q    <= second_d;
            is_pm_q     <= is_pm_d;
            set_hour_q  <= set_hour_d;
            set_min_q   <= set_min_d;
            set_is_pm_q <= set_is_pm_d;
            sec_tick_q  <= sec_tick_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prescaler_d = presc_tc ? '0 : prescaler_q + PW'(1);
        hour_d      = hour_q;
        minute_d    = minute_q;
        second_d    = second_q;
        is_pm_d     = is_pm_q;
        set_hour_d  = set_hour_q;
        set_min_d   = set_min_q;
        set_is_pm_d = set_is_pm_q;
        sec_tick_d  = presc_tc;

        if (presc_tc) begin
            if (second_q == 6'd59) begin
                second_d = 6'd0;
                if (minute_q == 6'd59) begin
                    minute_d = 6'd0;
                    if (hour_q == 4'd12) begin
                        hour_d = 4'd1;
                    end else begin
                        hour_d = hour_q + 4'd1;
                        if (hour_q == 4'd11) begin
                            is_pm_d = ~is_pm_q;
                        end
                    end
                end else begin
                    minute_d = minute_q + 6'd1;
                end
            end else begin
                second_d = second_q + 6'd1;
            end
        end

        if (!is_on_i) begin
            state_d = S_IDLE;
        end else if (btn_set_i) begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_SET_HOUR;
                    set_hour_d  = hour_q;
                    set_min_d   = minute_q;
                    set_is_pm_d = is_pm_q;
                end
                S_SET_HOUR: state_d = S_SET_MIN;
                S_SET_MIN:  state_d = S_SET_AMPM;
                default: begin
                    // commit wins over a coincident terminal count: that second is discarded
                    state_d     = S_IDLE;
                    hour_d      = set_hour_q;
                    minute_d    = set_min_q;
                    is_pm_d     = set_is_pm_q;
                    second_d    = 6'd0;
                    prescaler_d = '0;
                    sec_tick_d  = 1'b0;
                end
            endcase
        end else if (btn_up_i) begin
            case (state_q)
                S_SET_HOUR: set_hour_d  = (set_hour_q == 4'd12) ? 4'd1 : set_hour_q + 4'd1;
                S_SET_MIN:  set_min_d   = (set_min_q == 6'd59) ? 6'd0 : set_min_q + 6'd1;
                S_SET_AMPM: set_is_pm_d = ~set_is_pm_q;
                default:    ;
            endcase
        end
    end

    assign hour_o              = hour_q;
    assign minute_o            = minute_q;
    assign second_o            = second_q;
    assign is_pm_o             = is_pm_q;
    assign current_set_state_o = state_q;
    assign set_hour_o          = set_hour_q;
    assign set_min_o           = set_min_q;
    assign set_isPM_o          = set_is_pm_q;
    assign sec_tick_o          = sec_tick_q;

endmodule

// File: tb/tb_clock12_timekeeper.sv
// Scoreboard bench for clock12_timekeeper with TICKS_PER_SEC=4 and hand-computed expectations.
module tb_clock12_timekeeper;

    localparam int SEL_HOUR = 0, SEL_MIN = 1, SEL_SEC = 2, SEL_PM = 3, SEL_STATE = 4;
    localparam int SEL_SHOUR = 5, SEL_SMIN = 6, SEL_SPM = 7, SEL_TICK = 8;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, is_on, btn_set, btn_up;
    logic [3:0] hour, set_hour;
    logic [5:0] minute, second, set_min;
    logic       is_pm, set_isPM, sec_tick;
    logic [1:0] state;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    clock12_timekeeper #(.TICKS_PER_SEC(4)) dut (
        .clk_i(clk), .rst_i(rst), .is_on_i(is_on), .btn_set_i(btn_set), .btn_up_i(btn_up),
        .hour_o(hour), .minute_o(minute), .second_o(second), .is_pm_o(is_pm),
        .current_set_state_o(state), .set_hour_o(set_hour), .set_min_o(set_min),
        .set_isPM_o(set_isPM), .sec_tick_o(sec_tick)
    );

    always #5 clk = ~clk;

    function automatic int get_out(input int sel);
        case (sel)
            SEL_HOUR:  return int'(hour);
            SEL_MIN:   return int'(minute);
            SEL_SEC:   return int'(second);
            SEL_PM:    return int'(is_pm);
            SEL_STATE: return int'(state);
            SEL_SHOUR: return int'(set_hour);
            SEL_SMIN:  return int'(set_min);
            SEL_SPM:   return int'(set_isPM);
            default:   return int'(sec_tick);
        endcase
    endfunction

    // monitor: outputs settle after posedge; compare everything queued on the following negedge
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                int   act;
                e = exp_q.pop_front();
                act = get_out(e.sel);
                checks++;
                if (act != e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_out(input string name, input int sel, input int val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_time(input string tag, input int h, input int m, input int s, input int pm);
        expect_out({tag, "_hour"}, SEL_HOUR, h);
        expect_out({tag, "_min"},  SEL_MIN,  m);
        expect_out({tag, "_sec"},  SEL_SEC,  s);
        expect_out({tag, "_pm"},   SEL_PM,   pm);
    endtask

    task automatic expect_reset(input string tag);
        expect_time(tag, 12, 0, 0, 0);
        expect_out({tag, "_state"}, SEL_STATE, 0);
        expect_out({tag, "_shour"}, SEL_SHOUR, 12);
        expect_out({tag, "_smin"},  SEL_SMIN,  0);
        expect_out({tag, "_spm"},   SEL_SPM,   0);
        expect_out({tag, "_tick"},  SEL_TICK,  0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_set();
        btn_set = 1'b1;
        tick(1);
        btn_set = 1'b0;
    endtask

    task automatic press_up(input int n);
        repeat (n) begin
            btn_up = 1'b1;
            tick(1);
            btn_up = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; is_on = 1'b1; btn_set = 1'b0; btn_up = 1'b0;
        tick(2);
        expect_reset("reset");
        rst = 1'b0;

        // 1: tick every 4th cycle, 12:00:02 AM after 8 cycles
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            expect_out($sformatf("tick_c%0d", i), SEL_TICK, (i % 4 == 0) ? 1 : 0);
        end
        expect_time("run8", 12, 0, 2, 0);

        // 2a: preload 11:59 AM, run to 11:59:59, then roll to 12:00:00 PM
        press_set();
        expect_out("copy_state", SEL_STATE, 1);
        expect_out("copy_shour", SEL_SHOUR, 12);
        press_up(11);
        expect_out("shour_11", SEL_SHOUR, 11);
        press_set();
        press_up(59);
        expect_out("smin_59", SEL_SMIN, 59);
        press_set();
        expect_out("ampm_state", SEL_STATE, 3);
        press_set();
        expect_time("commit1159", 11, 59, 0, 0);
        expect_out("commit_state", SEL_STATE, 0);
        expect_out("commit_tick", SEL_TICK, 0);
        tick(236);
        expect_time("t115959", 11, 59, 59, 0);
        tick(4);
        expect_time("noon", 12, 0, 0, 1);
        expect_out("noon_tick", SEL_TICK, 1);

        // 2b: preload 12:59 PM, roll to 1:00:00 PM without toggling
        press_set();
        expect_out("copy_spm", SEL_SPM, 1);
        press_set();
        press_up(59);
        press_set();
        press_set();
        expect_time("commit1259", 12, 59, 0, 1);
        tick(240);
        expect_time("one_pm", 1, 0, 0, 1);

        // 3: staged hour edits leave running time alone until commit
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        press_set();
        press_up(3);
        expect_out("sh3_shour", SEL_SHOUR, 3);
        expect_out("sh3_hour", SEL_HOUR, 12);
        expect_out("sh3_state", SEL_STATE, 1);
        press_set();
        press_set();
        press_set();
        expect_time("commit3", 3, 0, 0, 0);
        expect_out("commit3_state", SEL_STATE, 0);

        // 4: minute wrap without hour carry, AM/PM toggle
        press_set();
        press_set();
        press_up(59);
        expect_out("m59", SEL_SMIN, 59);
        press_up(1);
        expect_out("mwrap_smin", SEL_SMIN, 0);
        expect_out("mwrap_shour", SEL_SHOUR, 3);
        press_set();
        press_up(1);
        expect_out("ampm_toggle", SEL_SPM, 1);

        // 5: btn_set beats btn_up
        press_set();
        expect_time("commit3pm", 3, 0, 0, 1);
        press_set();
        btn_set = 1'b1; btn_up = 1'b1;
        tick(1);
        btn_set = 1'b0; btn_up = 1'b0;
        expect_out("both_state", SEL_STATE, 2);
        expect_out("both_shour", SEL_SHOUR, 3);

        // 6: is_on low aborts set mode, ignores buttons, time keeps running
        is_on = 1'b0;
        tick(1);
        expect_out("off_state", SEL_STATE, 0);
        expect_time("off", 3, 0, 0, 1);
        expect_out("off_shour", SEL_SHOUR, 3);
        press_set();
        expect_out("off_btn_state", SEL_STATE, 0);
        expect_out("off_sec", SEL_SEC, 1);
        expect_out("off_tick", SEL_TICK, 1);
        tick(4);
        expect_out("off_sec2", SEL_SEC, 2);
        is_on = 1'b1;
        press_set();
        press_set();
        press_set();
        expect_out("pre_rst_state", SEL_STATE, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_reset("midset_rst");

        tick(2);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
